// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences the shared ALU,
// unified memory port and write enables across fetch/decode/execute/mem/wb.
module multicycle_ctrl #(
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [3:0] state,
  output logic [1:0] fault
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JMP      = 4'd12,
    S_LUI      = 4'd13,
    S_FAULT    = 4'd14
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);
  localparam logic             TO_EN = (STALL_LIMIT > 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fault_q, fault_d;
  logic             req_st;
  logic             limit_hit;

  assign req_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                  (state_q == S_MEMWRITE);
  assign limit_hit = TO_EN && (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Stall counter: only waiting request states accumulate, saturating.
  always_comb begin
    cnt_d = '0;
    if (req_st && !mem_ready) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (limit_hit) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JMP;
          OP_JALR:      state_d = S_JALR_ADR;
          OP_AUI:       state_d = S_ALUWB;
          OP_LUI:       state_d = S_LUI;
          default: begin
            state_d = S_FAULT;
            fault_d = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD, S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = (state_q == S_MEMWRITE);
        adr_src   = 1'b1;
        if (mem_ready) begin
          state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (limit_hit) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JMP;
      end
      S_JMP: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    unique case (op)
      OP_SW:          imm_src = 3'b001;
      OP_B:           imm_src = 3'b010;
      OP_JAL:         imm_src = 3'b011;
      OP_AUI, OP_LUI: imm_src = 3'b100;
      default:        imm_src = 3'b000;
    endcase
  end

  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus
// hand-written stall-timeout and mid-access reset sequences.
module tb_multicycle_ctrl;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RR   = 7'b0110011;
  localparam logic [6:0] II   = 7'b0010011;
  localparam logic [6:0] BB   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] AUI  = 7'b0010111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic       clk;
  logic       reset_n;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_update;
  logic       branch, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state;
  logic [1:0] fault;

  int n_chk;
  int n_fail;

  multicycle_ctrl #(.STALL_LIMIT(16), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_update(pc_update), .branch(branch),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .imm_src(imm_src),
    .state(state), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [1:0] flt;
  } vec_t;

  vec_t vq[$];

  // {mem_req,mem_write,adr_src,ir_write,pc_update,branch,reg_write,a,b,rs,aop}
  function automatic logic [14:0] spec_ctrl(input logic [3:0] st,
                                            input logic rdy);
    logic [14:0] c;
    c = '0;
    case (st)
      4'd1:  c = {1'b1, 1'b0, 1'b0, rdy, rdy, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
      4'd2:  c = {7'b0, 2'b01, 2'b01, 2'b00, 2'b00};
      4'd3:  c = {7'b0, 2'b10, 2'b01, 2'b00, 2'b00};
      4'd4:  c = {7'b1010000, 8'h00};
      4'd5:  c = {7'b0000001, 2'b00, 2'b00, 2'b01, 2'b00};
      4'd6:  c = {7'b1110000, 8'h00};
      4'd7:  c = {7'b0, 2'b10, 2'b00, 2'b00, 2'b10};
      4'd8:  c = {7'b0, 2'b10, 2'b01, 2'b00, 2'b10};
      4'd9:  c = {7'b0000001, 8'h00};
      4'd10: c = {7'b0000010, 2'b10, 2'b00, 2'b00, 2'b01};
      4'd11: c = {7'b0, 2'b10, 2'b01, 2'b00, 2'b00};
      4'd12: c = {7'b0000100, 2'b01, 2'b10, 2'b00, 2'b00};
      4'd13: c = {7'b0000001, 2'b00, 2'b00, 2'b11, 2'b00};
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] spec_imm(input logic [6:0] o);
    case (o)
      SW:       return 3'b001;
      BB:       return 3'b010;
      JAL:      return 3'b011;
      AUI, LUI: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic logic [14:0] dut_ctrl();
    return {mem_req, mem_write, adr_src, ir_write, pc_update, branch,
            reg_write, alu_src_a, alu_src_b, result_src, alu_op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [6:0] o, input logic y,
                     input logic [3:0] s, input logic [1:0] f);
    vq.push_back('{rst: r, op: o, rdy: y, st: s, flt: f});
  endtask

  task automatic drive(input logic r, input logic [6:0] o, input logic y);
    @(negedge clk);
    reset_n   = r;
    op        = o;
    mem_ready = y;
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    op        = RR;
    mem_ready = 1'b1;

    // R-type from reset release
    add(0, RR, 1, 0, 0);
    add(1, RR, 1, 0, 0);
    add(1, RR, 1, 1, 0);
    add(1, RR, 1, 2, 0);
    add(1, RR, 0, 7, 0);
    add(1, RR, 1, 9, 0);
    // lw with 3 wait cycles
    add(1, LW, 1, 1, 0);
    add(1, LW, 0, 2, 0);
    add(1, LW, 1, 3, 0);
    add(1, LW, 0, 4, 0);
    add(1, LW, 0, 4, 0);
    add(1, LW, 0, 4, 0);
    add(1, LW, 1, 4, 0);
    add(1, LW, 1, 5, 0);
    // sw
    add(1, SW, 1, 1, 0);
    add(1, SW, 1, 2, 0);
    add(1, SW, 0, 3, 0);
    add(1, SW, 1, 6, 0);
    // branch
    add(1, BB, 1, 1, 0);
    add(1, BB, 1, 2, 0);
    add(1, BB, 1, 10, 0);
    // jalr
    add(1, JALR, 1, 1, 0);
    add(1, JALR, 1, 2, 0);
    add(1, JALR, 1, 11, 0);
    add(1, JALR, 1, 12, 0);
    add(1, JALR, 1, 9, 0);
    // jal
    add(1, JAL, 1, 1, 0);
    add(1, JAL, 1, 2, 0);
    add(1, JAL, 1, 12, 0);
    add(1, JAL, 1, 9, 0);
    // auipc
    add(1, AUI, 1, 1, 0);
    add(1, AUI, 1, 2, 0);
    add(1, AUI, 1, 9, 0);
    // lui
    add(1, LUI, 1, 1, 0);
    add(1, LUI, 1, 2, 0);
    add(1, LUI, 1, 13, 0);
    // I-ALU
    add(1, II, 1, 1, 0);
    add(1, II, 1, 2, 0);
    add(1, II, 1, 8, 0);
    add(1, II, 1, 9, 0);
    // illegal opcode, sticky fault, then reset
    add(1, BAD, 1, 1, 0);
    add(1, BAD, 1, 2, 0);
    add(1, BAD, 1, 14, 1);
    add(1, BAD, 1, 14, 1);
    add(1, RR, 0, 14, 1);
    add(0, RR, 1, 0, 0);
    add(1, RR, 1, 0, 0);
    add(1, RR, 1, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].op, vq[i].rdy);
      chk($sformatf("v%0d.state", i), 32'(state), 32'(vq[i].st));
      chk($sformatf("v%0d.fault", i), 32'(fault), 32'(vq[i].flt));
      chk($sformatf("v%0d.ctrl", i), 32'(dut_ctrl()),
          32'(spec_ctrl(vq[i].st, vq[i].rdy)));
      chk($sformatf("v%0d.imm", i), 32'(imm_src), 32'(spec_imm(vq[i].op)));
    end

    // Timeout: 16 stall cycles fill the counter, the 17th faults
    drive(0, RR, 0);
    drive(1, RR, 0);
    chk("to.idle", 32'(state), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      drive(1, RR, 0);
      chk($sformatf("to.fetch%0d", k), 32'(state), 32'd1);
      chk($sformatf("to.req%0d", k), 32'(mem_req), 32'd1);
    end
    drive(1, RR, 0);
    chk("to.state", 32'(state), 32'd14);
    chk("to.fault", 32'(fault), 32'd2);
    chk("to.req_drop", 32'(mem_req), 32'd0);
    drive(1, RR, 1);
    chk("to.sticky", 32'(fault), 32'd2);

    // Ready on the limit cycle wins over the timeout
    drive(0, RR, 0);
    drive(1, RR, 0);
    for (int k = 1; k <= 16; k++) begin
      drive(1, RR, 0);
    end
    drive(1, RR, 1);
    chk("lim.fetch", 32'(state), 32'd1);
    chk("lim.ir_write", 32'(ir_write), 32'd1);
    drive(1, RR, 0);
    chk("lim.decode", 32'(state), 32'd2);
    chk("lim.nofault", 32'(fault), 32'd0);

    // Asynchronous reset in the middle of a load access
    drive(1, LW, 1);
    chk("mid.exec", 32'(state), 32'd7);
    drive(1, LW, 1);
    drive(1, LW, 1);
    drive(1, LW, 0);
    drive(1, LW, 0);
    drive(1, LW, 0);
    chk("mid.memread", 32'(state), 32'd4);
    chk("mid.req", 32'(mem_req), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid.rst_state", 32'(state), 32'd0);
    chk("mid.rst_req", 32'(mem_req), 32'd0);
    chk("mid.rst_adr", 32'(adr_src), 32'd0);
    drive(1, RR, 1);
    drive(1, RR, 1);
    chk("mid.refetch", 32'(state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It sequences the shared ALU, the single unified memory port, IR/PC/register-file writes and result muxing across FETCH/DECODE/EXECUTE/MEM/WB steps. It takes `op` from the latched IR and `mem_ready` from memory, and drives datapath select and enable lines.
Outside this block, ALUOp is expanded by the ALU decoder, and PC write is computed as `pc_update | (branch & taken)`.

Parameters:
STALL_LIMIT, 16, maximum wait cycles for `mem_ready` per memory access; 0 disables the timeout.
CNT_W, 5, width of the stall counter; must hold STALL_LIMIT.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
op  in  7  opcode, IR[6:0]; stable from DECODE until the next FETCH.
mem_ready  in  1  memory completes the current request this cycle.
mem_req  out  1  memory request valid.
mem_write  out  1  request is a store; only with `mem_req`.
adr_src  out  1  0 = PC, 1 = Result (ALUOut).
ir_write  out  1  latch instruction and OldPC.
pc_update  out  1  unconditional PC write.
branch  out  1  conditional PC write.
reg_write  out  1  register-file write enable.
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 register.
alu_src_b  out  2  00 rs2 register, 01 ImmExt, 10 constant 4.
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded.
imm_src  out  3  combinational from `op`:
  - lw / I-ALU / jalr → 000
  - sw → 001
  - B-type → 010
  - jal → 011
  - auipc / lui → 100
  - other → 000
state  out  4  current state encoding (debug).
fault  out  2  sticky: 01 illegal opcode, 10 memory timeout; 00 while running.

Behaviour:
- Moore FSM: all outputs decode from `state` only. Exceptions: `imm_src`, and `ir_write`/`pc_update` in FETCH, which equal `mem_ready`.
- Every output not listed for a state is 0.
- Reset (`reset_n` low, any cycle, including mid-access) has immediate effect:
  - state = IDLE, all outputs 0, `fault` = 00, stall counter = 0.
  - Any in-flight memory request is abandoned.

State encodings, outputs and transitions:
- IDLE (0): no outputs. → FETCH unconditionally, so the first `mem_req` appears one cycle after reset release.
- FETCH (1): `mem_req`, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10; `ir_write` = `pc_update` = `mem_ready`. Stays until `mem_ready`, then → DECODE.
- DECODE (2): `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (ALUOut ← OldPC+imm). Next state by `op`:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JMP
  - 1100111 → JALR_ADR
  - 0010111 → ALUWB
  - 0110111 → LUI
  - any other → FAULT with `fault`=01
- MEMADR (3): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. `op` 0000011 → MEMREAD, else → MEMWRITE.
- MEMREAD (4): `mem_req`, `adr_src`=1, `result_src`=00. On `mem_ready` → MEMWB.
- MEMWB (5): `result_src`=01, `reg_write`. → FETCH.
- MEMWRITE (6): `mem_req`, `mem_write`, `adr_src`=1, `result_src`=00. On `mem_ready` → FETCH.
- EXECR (7): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. → ALUWB.
- EXECI (8): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. → ALUWB.
- ALUWB (9): `result_src`=00, `reg_write`. → FETCH.
- BRANCH (10): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`. → FETCH.
- JALR_ADR (11): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. → JMP.
- JMP (12): `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_update`. → ALUWB (writes OldPC+4).
- LUI (13): `result_src`=11, `reg_write`. → FETCH.
- FAULT (14): all outputs 0 except `fault`. Stays until reset.

Stall counter and timeout:
- Counts cycles spent in FETCH, MEMREAD or MEMWRITE with `mem_ready`=0.
- Clears on `mem_ready` or on entry to any other state; saturates at its maximum.
- If STALL_LIMIT>0 and the counter equals STALL_LIMIT while `mem_ready`=0 → FAULT with `fault`=10. `mem_req` drops the next cycle.
- `mem_ready` in the same cycle the limit is reached wins: normal transition, no fault.
- `mem_ready` outside a request state is ignored.

Cycle counts with zero-wait memory:
- lw 5; sw 4; R/I 4; branch 3; jal 4; jalr 5; auipc 3; lui 3.

Test Plan:
- Reset release with `mem_ready`=1 and `op`=0110011: cycles after release show `state` 0→1→2→7→9→1; `reg_write`=1 only in ALUWB; `ir_write`=`pc_update`=1 in FETCH.
- lw with `mem_ready` low for 3 cycles in MEMREAD: `mem_req`=1 and `adr_src`=1 held for 4 cycles; MEMWB follows with `result_src`=01 and `reg_write`=1; the access has no effect on `fault`.
- sw: MEMWRITE asserts `mem_write`=`mem_req`=1, then FETCH; `reg_write` is never asserted during the instruction.
- jalr (`op`=1100111): sequence 2→11→12→9; JMP drives `pc_update`=1 with `alu_src_a`=01, `alu_src_b`=10; `imm_src`=000 throughout.
- `op`=1111111 in DECODE: next cycle `state`=14, `fault`=01, `mem_req`=0 forever. Pulsing `reset_n` low returns to IDLE with `fault`=00.
- STALL_LIMIT=16, `mem_ready` held 0 in FETCH: FAULT with `fault`=10 after the 16th stall cycle. Rerun with `mem_ready`=1 on exactly that cycle: DECODE is entered and no fault is raised.
